sha_job_link: RTL



---
 rtl/sha_job_link.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/sha_job_link.sv
// sha_job_link
//   Byte-stream host link for the double-SHA256 nonce-search engine.
//   A job frame (sync byte + 132 payload bytes) is assembled into the
//   engine's job fields.  job_valid then pulses for one cycle.  The block
//   waits for the engine's found result, then returns a 37-byte response
//   frame (sync, nonce, hash).
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   rx_data/valid/ready incoming byte stream from the host bridge
//   tx_data/valid/ready outgoing byte stream to the host bridge
//   job_valid           one-cycle job start to the engine
//   job_data            64 message block bytes
//   job_state           8 midstate words
//   job_nonce_base      first nonce to try
//   job_target          32 target bytes (element 31 = MSB)
//   res_valid           engine found flag (level)
//   res_result          engine hash (element 31 sent first)
//   res_nonce           engine winning nonce
//   busy                high while a job is launched, running or replying
//   err_count           saturating count of timed-out frames
module sha_job_link #(
  parameter logic [7:0] SYNC_RX = 8'hA5,
  parameter logic [7:0] SYNC_TX = 8'h5A,
  parameter int         TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              job_valid,
  output logic [63:0][7:0]  job_data,
  output logic [7:0][31:0]  job_state,
  output logic [31:0]       job_nonce_base,
  output logic [31:0][7:0]  job_target,
  input  logic              res_valid,
  input  logic [31:0][7:0]  res_result,
  input  logic [31:0]       res_nonce,
  output logic              busy,
  output logic [7:0]        err_count
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    ST_HUNT,
    ST_LOAD,
    ST_LAUNCH,
    ST_WAIT,
    ST_SEND
  } state_t;

  state_t         state;
  logic [7:0]     idx;
  logic [TW-1:0]  timer;
  logic           settle;     // marks the first WAIT cycle, where res_valid is ignored
  logic [287:0]   tx_shift;   // remaining response bytes, next byte in the top 8 bits
  logic [5:0]     tx_count;

  logic           rx_fire;
  logic           tx_fire;
  logic [4:0]     bsh;        // bit offset of a big-endian byte within a 32-bit word
  logic [7:0]     tgt_k;

  assign rx_fire = rx_valid && rx_ready;
  assign tx_fire = tx_valid && tx_ready;
  // The first byte of a word lands in bits 31:24, so the offset is (3 - k%4)*8.
  assign bsh     = {~idx[1:0], 3'b000};
  // The target is sent MSB element first.
  assign tgt_k   = 8'd131 - idx;
  assign busy    = (state == ST_LAUNCH) || (state == ST_WAIT) || (state == ST_SEND);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= ST_HUNT;
      idx            <= '0;
      timer          <= '0;
      settle         <= 1'b0;
      tx_shift       <= '0;
      tx_count       <= '0;
      rx_ready       <= 1'b0;
      tx_data        <= '0;
      tx_valid       <= 1'b0;
      job_valid      <= 1'b0;
      job_data       <= '0;
      job_state      <= '0;
      job_nonce_base <= '0;
      job_target     <= '0;
      err_count      <= '0;
    end else begin
      job_valid <= 1'b0;
      case (state)
        ST_HUNT: begin
          rx_ready <= 1'b1;
          if (rx_fire && rx_data == SYNC_RX) begin
            state <= ST_LOAD;
            idx   <= '0;
            timer <= '0;
          end
        end

        ST_LOAD: begin
          if (rx_fire) begin
            timer <= '0;
            if (idx < 8'd64)
              job_data[idx[5:0]] <= rx_data;
            else if (idx < 8'd96)
              job_state[idx[4:2]][bsh +: 8] <= rx_data;
            else if (idx < 8'd100)
              job_nonce_base[bsh +: 8] <= rx_data;
            else
              job_target[tgt_k[4:0]] <= rx_data;

            if (idx == 8'd131) begin
              state     <= ST_LAUNCH;
              job_valid <= 1'b1;
              rx_ready  <= 1'b0;
            end else begin
              idx <= idx + 8'd1;
            end
          end else if (timer == TIMER_LAST) begin
            // Frame abandoned; partial field contents are left in place.
            state <= ST_HUNT;
            timer <= '0;
            if (err_count != 8'hFF)
              err_count <= err_count + 8'd1;
          end else begin
            timer <= timer + 1'b1;
          end
        end

        ST_LAUNCH: begin
          state    <= ST_WAIT;
          rx_ready <= 1'b1;
          settle   <= 1'b1;
        end

        ST_WAIT: begin
          settle <= 1'b0;
          // A new sync byte supersedes the running job, even if a result arrives now.
          if (rx_fire && rx_data == SYNC_RX) begin
            state <= ST_LOAD;
            idx   <= '0;
            timer <= '0;
          end else if (!settle && res_valid) begin
            state    <= ST_SEND;
            rx_ready <= 1'b0;
            tx_valid <= 1'b1;
            tx_data  <= SYNC_TX;
            tx_shift <= {res_nonce, res_result};
            tx_count <= '0;
          end
        end

        ST_SEND: begin
          if (tx_fire) begin
            if (tx_count == 6'd36) begin
              tx_valid <= 1'b0;
              state    <= ST_HUNT;
              rx_ready <= 1'b1;
            end else begin
              tx_data  <= tx_shift[287:280];
              tx_shift <= tx_shift << 8;
              tx_count <= tx_count + 6'd1;
            end
          end
        end

        default: begin
          state    <= ST_HUNT;
          rx_ready <= 1'b0;
          tx_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
